// File: rtl/dmac_burst_buffer.sv
// Command and data FIFOs in front of a DMA write engine. Bursts go to the read side one at a time.
// With STORE_FWD=1 a command is held back until its whole burst is buffered.
module dmac_burst_buffer #(
  parameter int ADDR_WD       = 32,
  parameter int DATA_WD       = 32,
  parameter int CMD_DEPTH     = 8,
  parameter int DATA_DEPTH    = 32,
  parameter int MAX_BURST_LEN = 16,
  parameter int STORE_FWD     = 1
) (
  input  logic                          clk,
  input  logic                          rst,

  input  logic                          cmd_in_valid,
  output logic                          cmd_in_ready,
  input  logic [$clog2(ADDR_WD/8)-1:0]  cmd_in_src_offset,
  input  logic [ADDR_WD-1:0]            cmd_in_dst_addr,
  input  logic [1:0]                    cmd_in_burst,
  input  logic [ADDR_WD-1:0]            cmd_in_len,
  input  logic [2:0]                    cmd_in_size,

  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  input  logic [DATA_WD-1:0]            data_in,
  input  logic                          data_in_last,

  output logic                          cmd_out_valid,
  input  logic                          cmd_out_ready,
  output logic [$clog2(ADDR_WD/8)-1:0]  cmd_out_src_offset,
  output logic [ADDR_WD-1:0]            cmd_out_dst_addr,
  output logic [1:0]                    cmd_out_burst,
  output logic [ADDR_WD-1:0]            cmd_out_len,
  output logic [2:0]                    cmd_out_size,

  output logic                          data_out_valid,
  input  logic                          data_out_ready,
  output logic [DATA_WD-1:0]            data_out,
  output logic                          data_out_last,

  output logic [$clog2(CMD_DEPTH):0]    cmd_count,
  output logic [$clog2(DATA_DEPTH):0]   data_count,
  output logic [$clog2(DATA_DEPTH):0]   burst_count,
  output logic                          err_burst_len
);

  localparam int OFF_WD  = $clog2(ADDR_WD/8);
  localparam int CMD_AW  = $clog2(CMD_DEPTH);
  localparam int DATA_AW = $clog2(DATA_DEPTH);
  localparam int BEAT_W  = $clog2(MAX_BURST_LEN + 1);
  localparam int CMD_W   = OFF_WD + 2*ADDR_WD + 5;

  localparam logic [CMD_AW:0]   CMD_FULL   = (CMD_AW+1)'(CMD_DEPTH);
  localparam logic [CMD_AW:0]   CMD_ONE    = (CMD_AW+1)'(1);
  localparam logic [DATA_AW:0]  DATA_FULL  = (DATA_AW+1)'(DATA_DEPTH);
  localparam logic [DATA_AW:0]  DATA_ONE   = (DATA_AW+1)'(1);
  localparam logic [BEAT_W-1:0] BEAT_LIMIT = BEAT_W'(MAX_BURST_LEN - 1);
  localparam logic [BEAT_W-1:0] BEAT_SAT   = BEAT_W'(MAX_BURST_LEN);

  logic [CMD_W-1:0]   cmd_mem  [CMD_DEPTH];
  logic [DATA_WD:0]   data_mem [DATA_DEPTH];
  logic [CMD_AW-1:0]  cmd_wr_ptr, cmd_rd_ptr;
  logic [DATA_AW-1:0] data_wr_ptr, data_rd_ptr;
  logic [BEAT_W-1:0]  beat_cnt;
  logic               open_burst;
  logic               cmd_space, data_space;
  logic               cmd_wr, cmd_rd, data_wr, data_rd;
  logic               burst_in, burst_out;

  // Space is taken from registered counts only, so a same-cycle read never opens a slot early.
  assign cmd_space     = (cmd_count < CMD_FULL);
  assign data_space    = (data_count < DATA_FULL);
  assign cmd_in_ready  = !rst && cmd_space;
  assign data_in_ready = !rst && data_space;

  assign cmd_out_valid  = (cmd_count != '0) && !open_burst &&
                          ((STORE_FWD == 0) || (burst_count != '0));
  assign data_out_valid = (data_count != '0) && open_burst;

  assign cmd_wr    = cmd_in_valid && cmd_space;
  assign cmd_rd    = cmd_out_valid && cmd_out_ready;
  assign data_wr   = data_in_valid && data_space;
  assign data_rd   = data_out_valid && data_out_ready;
  assign burst_in  = data_wr && data_in_last;
  assign burst_out = data_rd && data_out_last;

  // The read pointer only moves on a handshake, so a stalled payload is held as it is.
  assign {cmd_out_src_offset, cmd_out_dst_addr, cmd_out_burst, cmd_out_len, cmd_out_size} =
    cmd_mem[cmd_rd_ptr];
  assign {data_out, data_out_last} = data_mem[data_rd_ptr];

  // NOTE: storage arrays are not reset; the pointers and counts decide what is valid.
  always_ff @(posedge clk) begin
    if (cmd_wr)
      cmd_mem[cmd_wr_ptr] <= {cmd_in_src_offset, cmd_in_dst_addr, cmd_in_burst, cmd_in_len, cmd_in_size};
    if (data_wr)
      data_mem[data_wr_ptr] <= {data_in, data_in_last};
  end

  // NOTE: non-blocking assignments in clocked blocks, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_wr_ptr    <= '0;
      cmd_rd_ptr    <= '0;
      data_wr_ptr   <= '0;
      data_rd_ptr   <= '0;
      cmd_count     <= '0;
      data_count    <= '0;
      burst_count   <= '0;
      beat_cnt      <= '0;
      open_burst    <= 1'b0;
      err_burst_len <= 1'b0;
    end else begin
      if (cmd_wr)  cmd_wr_ptr  <= cmd_wr_ptr + CMD_AW'(1);
      if (cmd_rd)  cmd_rd_ptr  <= cmd_rd_ptr + CMD_AW'(1);
      if (data_wr) data_wr_ptr <= data_wr_ptr + DATA_AW'(1);
      if (data_rd) data_rd_ptr <= data_rd_ptr + DATA_AW'(1);

      case ({cmd_wr, cmd_rd})
        2'b10:   cmd_count <= cmd_count + CMD_ONE;
        2'b01:   cmd_count <= cmd_count - CMD_ONE;
        default: cmd_count <= cmd_count;
      endcase

      case ({data_wr, data_rd})
        2'b10:   data_count <= data_count + DATA_ONE;
        2'b01:   data_count <= data_count - DATA_ONE;
        default: data_count <= data_count;
      endcase

      case ({burst_in, burst_out})
        2'b10:   burst_count <= burst_count + DATA_ONE;
        2'b01:   burst_count <= burst_count - DATA_ONE;
        default: burst_count <= burst_count;
      endcase

      // cmd_rd needs open_burst=0 and burst_out needs open_burst=1, so they never coincide.
      if (cmd_rd)         open_burst <= 1'b1;
      else if (burst_out) open_burst <= 1'b0;

      // The beat counter saturates so a runaway burst cannot wrap it back into range.
      if (data_wr) begin
        if (data_in_last) begin
          beat_cnt <= '0;
        end else begin
          if (beat_cnt == BEAT_LIMIT) err_burst_len <= 1'b1;
          if (beat_cnt != BEAT_SAT)   beat_cnt <= beat_cnt + BEAT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dmac_burst_buffer.sv
// Scoreboard bench for dmac_burst_buffer: directed bursts go into expectation queues and a
// negedge monitor pops them on every output handshake. A cut-through instance shares the inputs.
module tb_dmac_burst_buffer;

  typedef struct packed {
    logic [1:0]  off;
    logic [31:0] dst;
    logic [1:0]  burst;
    logic [31:0] len;
    logic [2:0]  size;
  } cmd_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        cmd_in_valid = 1'b0;
  logic [1:0]  cmd_in_src_offset = '0;
  logic [31:0] cmd_in_dst_addr = '0;
  logic [1:0]  cmd_in_burst = '0;
  logic [31:0] cmd_in_len = '0;
  logic [2:0]  cmd_in_size = '0;
  logic        data_in_valid = 1'b0;
  logic [31:0] data_in = '0;
  logic        data_in_last = 1'b0;
  logic        cmd_out_ready = 1'b0;
  logic        data_out_ready = 1'b0;
  logic        ct_cmd_out_ready = 1'b0;
  logic        ct_data_out_ready = 1'b0;

  logic        cmd_in_ready, data_in_ready, cmd_out_valid, data_out_valid;
  logic [1:0]  cmd_out_src_offset, cmd_out_burst;
  logic [31:0] cmd_out_dst_addr, cmd_out_len, data_out;
  logic [2:0]  cmd_out_size;
  logic        data_out_last, err_burst_len;
  logic [3:0]  cmd_count;
  logic [5:0]  data_count, burst_count;

  logic        ct_cmd_in_ready, ct_data_in_ready, ct_cmd_out_valid, ct_data_out_valid;
  logic [1:0]  ct_cmd_out_src_offset, ct_cmd_out_burst;
  logic [31:0] ct_cmd_out_dst_addr, ct_cmd_out_len, ct_data_out;
  logic [2:0]  ct_cmd_out_size;
  logic        ct_data_out_last, ct_err_burst_len;
  logic [3:0]  ct_cmd_count;
  logic [5:0]  ct_data_count, ct_burst_count;

  cmd_t  exp_cmd[$];
  beat_t exp_beat[$];
  cmd_t  mon_cmd;
  beat_t mon_beat;
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  dmac_burst_buffer #(
    .ADDR_WD(32), .DATA_WD(32), .CMD_DEPTH(8), .DATA_DEPTH(32), .MAX_BURST_LEN(16), .STORE_FWD(1)
  ) u_dut (
    .clk(clk), .rst(rst),
    .cmd_in_valid(cmd_in_valid), .cmd_in_ready(cmd_in_ready),
    .cmd_in_src_offset(cmd_in_src_offset), .cmd_in_dst_addr(cmd_in_dst_addr),
    .cmd_in_burst(cmd_in_burst), .cmd_in_len(cmd_in_len), .cmd_in_size(cmd_in_size),
    .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .data_in(data_in), .data_in_last(data_in_last),
    .cmd_out_valid(cmd_out_valid), .cmd_out_ready(cmd_out_ready),
    .cmd_out_src_offset(cmd_out_src_offset), .cmd_out_dst_addr(cmd_out_dst_addr),
    .cmd_out_burst(cmd_out_burst), .cmd_out_len(cmd_out_len), .cmd_out_size(cmd_out_size),
    .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
    .data_out(data_out), .data_out_last(data_out_last),
    .cmd_count(cmd_count), .data_count(data_count), .burst_count(burst_count),
    .err_burst_len(err_burst_len)
  );

  dmac_burst_buffer #(
    .ADDR_WD(32), .DATA_WD(32), .CMD_DEPTH(8), .DATA_DEPTH(32), .MAX_BURST_LEN(16), .STORE_FWD(0)
  ) u_ct (
    .clk(clk), .rst(rst),
    .cmd_in_valid(cmd_in_valid), .cmd_in_ready(ct_cmd_in_ready),
    .cmd_in_src_offset(cmd_in_src_offset), .cmd_in_dst_addr(cmd_in_dst_addr),
    .cmd_in_burst(cmd_in_burst), .cmd_in_len(cmd_in_len), .cmd_in_size(cmd_in_size),
    .data_in_valid(data_in_valid), .data_in_ready(ct_data_in_ready),
    .data_in(data_in), .data_in_last(data_in_last),
    .cmd_out_valid(ct_cmd_out_valid), .cmd_out_ready(ct_cmd_out_ready),
    .cmd_out_src_offset(ct_cmd_out_src_offset), .cmd_out_dst_addr(ct_cmd_out_dst_addr),
    .cmd_out_burst(ct_cmd_out_burst), .cmd_out_len(ct_cmd_out_len), .cmd_out_size(ct_cmd_out_size),
    .data_out_valid(ct_data_out_valid), .data_out_ready(ct_data_out_ready),
    .data_out(ct_data_out), .data_out_last(ct_data_out_last),
    .cmd_count(ct_cmd_count), .data_count(ct_data_count), .burst_count(ct_burst_count),
    .err_burst_len(ct_err_burst_len)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: one expectation is consumed per output handshake (handshake completes at the next posedge).
  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_out_valid && cmd_out_ready) begin
        if (exp_cmd.size() == 0) begin
          check("cmd_out unexpected", 1, 0);
        end else begin
          mon_cmd = exp_cmd.pop_front();
          check("cmd_out payload",
                {cmd_out_src_offset, cmd_out_dst_addr, cmd_out_burst, cmd_out_len, cmd_out_size},
                mon_cmd);
        end
      end
      if (data_out_valid && data_out_ready) begin
        if (exp_beat.size() == 0) begin
          check("data_out unexpected", 1, 0);
        end else begin
          mon_beat = exp_beat.pop_front();
          check("data_out payload", {data_out, data_out_last}, mon_beat);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic put_cmd(input logic [1:0] off, input logic [31:0] dst, input logic [1:0] burst,
                         input logic [31:0] len, input logic [2:0] size);
    int n = 0;
    cmd_in_valid      = 1'b1;
    cmd_in_src_offset = off;
    cmd_in_dst_addr   = dst;
    cmd_in_burst      = burst;
    cmd_in_len        = len;
    cmd_in_size       = size;
    @(negedge clk);
    while (!cmd_in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("cmd_in_ready wait", cmd_in_ready, 1);
    if (cmd_in_ready) begin
      exp_cmd.push_back({off, dst, burst, len, size});
      @(posedge clk);
      #1;
    end
    cmd_in_valid = 1'b0;
  endtask

  task automatic put_beat(input logic [31:0] d, input logic last);
    int n = 0;
    data_in_valid = 1'b1;
    data_in       = d;
    data_in_last  = last;
    @(negedge clk);
    while (!data_in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("data_in_ready wait", data_in_ready, 1);
    if (data_in_ready) begin
      exp_beat.push_back({d, last});
      @(posedge clk);
      #1;
    end
    data_in_valid = 1'b0;
    data_in_last  = 1'b0;
  endtask

  task automatic wait_drained();
    int n = 0;
    cmd_out_ready  = 1'b1;
    data_out_ready = 1'b1;
    @(negedge clk);
    while ((cmd_count != 0 || data_count != 0) && n < 500) begin
      n++;
      @(negedge clk);
    end
    check("drain cmd_count", cmd_count, 0);
    check("drain data_count", data_count, 0);
    check("drain burst_count", burst_count, 0);
    check("drain cmds outstanding", exp_cmd.size(), 0);
    check("drain beats outstanding", exp_beat.size(), 0);
    cycle();
    cmd_out_ready  = 1'b0;
    data_out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_cmd.delete();
    exp_beat.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state and release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst cmd_in_ready", cmd_in_ready, 0);
    check("rst data_in_ready", data_in_ready, 0);
    check("rst out valids", {cmd_out_valid, data_out_valid}, 0);
    check("rst counts/err", {cmd_count, data_count, burst_count, err_burst_len}, 0);
    cycle();
    rst = 1'b0;
    @(negedge clk);
    check("release cmd_in_ready", cmd_in_ready, 1);
    check("release data_in_ready", data_in_ready, 1);
    cycle();

    // Store-and-forward: the command waits for its last beat.
    put_cmd(2'd1, 32'h1000, 2'd1, 32'd3, 3'd2);
    @(negedge clk);
    check("sf cmd_out_valid no data", cmd_out_valid, 0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      put_beat(32'hA000 + i, 1'b0);
      @(negedge clk);
      check("sf cmd_out_valid partial", cmd_out_valid, 0);
      cycle();
    end
    put_beat(32'hA003, 1'b1);
    @(negedge clk);
    check("sf cmd_out_valid complete", cmd_out_valid, 1);
    check("sf burst_count", burst_count, 1);
    check("sf data_out_valid before cmd", data_out_valid, 0);
    cycle();
    wait_drained();

    // Last beat in and last beat out in the same cycle.
    put_cmd(2'd0, 32'h2000, 2'd1, 32'd1, 3'd2);
    put_beat(32'hB000, 1'b0);
    put_beat(32'hB001, 1'b1);
    put_cmd(2'd3, 32'h3000, 2'd0, 32'd0, 3'd1);
    cmd_out_ready = 1'b1;
    @(negedge clk);
    check("sim first cmd offered", cmd_out_valid, 1);
    cycle();
    cmd_out_ready  = 1'b0;
    data_out_ready = 1'b1;
    cycle();
    put_beat(32'hC000, 1'b1);
    data_out_ready = 1'b0;
    @(negedge clk);
    check("sim burst_count", burst_count, 1);
    check("sim data_count", data_count, 1);
    check("sim burst closed, next cmd offered", cmd_out_valid, 1);
    check("sim data_out_valid", data_out_valid, 0);
    cycle();
    wait_drained();

    // Fill the data queue, then free one slot.
    put_cmd(2'd0, 32'h4000, 2'd1, 32'd7, 3'd2);
    for (int i = 0; i < 32; i++) put_beat(32'hD000 + i, (i % 8) == 7);
    @(negedge clk);
    check("fill data_count", data_count, 32);
    check("fill data_in_ready", data_in_ready, 0);
    check("fill burst_count", burst_count, 4);
    cycle();
    cmd_out_ready = 1'b1;
    cycle();
    cmd_out_ready  = 1'b0;
    data_out_ready = 1'b1;
    cycle();
    data_out_ready = 1'b0;
    @(negedge clk);
    check("fill data_count after read", data_count, 31);
    check("fill data_in_ready after read", data_in_ready, 1);
    cycle();
    for (int i = 0; i < 3; i++) put_cmd(i[1:0], 32'h5000 + i * 32'h100, 2'd2, 32'd7, 3'd2);
    wait_drained();

    // Over-long burst: the 16th beat without last raises the sticky error.
    for (int i = 0; i < 17; i++) begin
      put_beat(32'hE000 + i, 1'b0);
      @(negedge clk);
      check("err_burst_len during burst", err_burst_len, i >= 15);
      cycle();
    end
    put_beat(32'hE011, 1'b1);
    @(negedge clk);
    check("err_burst_len sticky", err_burst_len, 1);
    cycle();
    do_reset();
    @(negedge clk);
    check("err_burst_len cleared", err_burst_len, 0);
    cycle();

    // Asynchronous reset with content queued.
    put_cmd(2'd1, 32'h6000, 2'd1, 32'd2, 3'd2);
    put_cmd(2'd2, 32'h7000, 2'd1, 32'd1, 3'd2);
    for (int i = 0; i < 5; i++) put_beat(32'hF000 + i, (i == 2) || (i == 4));
    @(negedge clk);
    check("pre-rst counts", {cmd_count, data_count}, {4'd2, 6'd5});
    check("pre-rst cmd_out_valid", cmd_out_valid, 1);
    #2;
    rst = 1'b1;
    exp_cmd.delete();
    exp_beat.delete();
    #1;
    check("async rst counts", {cmd_count, data_count, burst_count}, 0);
    check("async rst out valids", {cmd_out_valid, data_out_valid}, 0);
    check("async rst in readies", {cmd_in_ready, data_in_ready}, 0);
    cycle();
    cycle();
    rst = 1'b0;
    @(negedge clk);
    check("after rst cmd_out_valid", cmd_out_valid, 0);
    check("after rst data_count", data_count, 0);
    cycle();
    put_cmd(2'd0, 32'h8000, 2'd0, 32'd0, 3'd0);
    put_beat(32'h1234ABCD, 1'b1);
    wait_drained();

    // Cut-through instance: command released before its burst is complete.
    do_reset();
    put_cmd(2'd1, 32'h9000, 2'd1, 32'd2, 3'd2);
    @(negedge clk);
    check("ct cmd_out_len", ct_cmd_out_len, 2);
    cycle();
    put_beat(32'h5555AAAA, 1'b0);
    @(negedge clk);
    check("ct cmd_out_valid", ct_cmd_out_valid, 1);
    check("ct data_out_valid before cmd hs", ct_data_out_valid, 0);
    check("sf cmd_out_valid on partial burst", cmd_out_valid, 0);
    cycle();
    ct_cmd_out_ready = 1'b1;
    cycle();
    ct_cmd_out_ready = 1'b0;
    @(negedge clk);
    check("ct data_out_valid after cmd hs", ct_data_out_valid, 1);
    check("ct cmd_out_valid after cmd hs", ct_cmd_out_valid, 0);
    check("ct data_out", {ct_data_out, ct_data_out_last}, {32'h5555AAAA, 1'b0});
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmac_burst_buffer.md
DMAC_BURST_BUFFER -- requirements
Module: dmac_burst_buffer

Interface
REQ-001 SHALL have parameter ADDR_WD, default 32: address and length width.
REQ-002 SHALL have parameter DATA_WD, default 32: data beat width.
REQ-003 SHALL have parameter CMD_DEPTH, default 8: command queue entries, power of two, >=2.
REQ-004 SHALL have parameter DATA_DEPTH, default 32: data queue entries, power of two, >=MAX_BURST_LEN.
REQ-005 SHALL have parameter MAX_BURST_LEN, default 16: maximum beats per burst.
REQ-006 SHALL have parameter STORE_FWD, default 1: 1 = release a command only once its whole burst is buffered; 0 = cut-through.
REQ-007 SHALL have the ports below; clock and reset are fixed as one clock, reset asynchronous and active-high.
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- cmd_in_valid/cmd_in_ready  in/out  1  command write handshake.
- cmd_in_src_offset  in  $clog2(ADDR_WD/8)  source byte offset.
- cmd_in_dst_addr  in  ADDR_WD  destination address.
- cmd_in_burst  in  2  burst type.
- cmd_in_len  in  ADDR_WD  beat count minus one.
- cmd_in_size  in  3  beat size code.
- data_in_valid/data_in_ready  in/out  1  data write handshake.
- data_in  in  DATA_WD  beat payload.
- data_in_last  in  1  final beat of burst.
- cmd_out_*  out/in(ready)  same widths as cmd_in_*  command read side.
- data_out_valid/data_out_ready, data_out, data_out_last  out/in  as data_in_*  data read side.
- cmd_count  out  $clog2(CMD_DEPTH)+1  queued commands.
- data_count  out  $clog2(DATA_DEPTH)+1  queued beats.
- burst_count  out  $clog2(DATA_DEPTH)+1  complete bursts (last beat written, not yet read out).
- err_burst_len  out  1  sticky: input burst exceeded MAX_BURST_LEN beats.

Function
REQ-008 SHALL store commands in order in a CMD_DEPTH FIFO; cmd_in_ready = (cmd_count < CMD_DEPTH).
REQ-009 SHALL store {data, last} in order in a DATA_DEPTH FIFO; data_in_ready = (data_count < DATA_DEPTH), independent of any same-cycle read.
REQ-010 SHALL make a written entry visible at the read side one cycle after the write handshake; no combinational input-to-output path.
REQ-011 SHALL keep an open_burst flag: set on cmd_out handshake, cleared on data_out handshake with data_out_last=1.
REQ-012 SHALL drive cmd_out_valid = cmd queue not empty AND open_burst=0 AND (STORE_FWD=0 OR burst_count>0).
REQ-013 SHALL drive data_out_valid = data queue not empty AND open_burst=1; at most one burst is outstanding on the output.
REQ-014 SHALL increment burst_count on a data_in handshake with last=1, decrement on a data_out handshake with last=1, and leave it unchanged when both occur in one cycle.
REQ-015 SHALL count input beats since the last data_in_last; when a beat is accepted with count = MAX_BURST_LEN-1 and last=0, SHALL set err_burst_len (sticky until reset) and keep accepting data.
REQ-016 SHALL update cmd_count and data_count by +1 on write, -1 on read, and 0 on simultaneous read and write.
REQ-017 SHALL wrap read and write pointers modulo depth; full/empty SHALL be derived from the counts.
REQ-018 SHALL hold all cmd_out_* and data_out* payloads stable while valid is high and ready is low.

Reset
REQ-019 SHALL, while rst=1 and asynchronously on assertion, clear pointers, all counts, open_burst, the beat counter and err_burst_len; cmd_out_valid=0, data_out_valid=0, cmd_in_ready=0, data_in_ready=0.
REQ-020 SHALL, in the first cycle after rst deasserts, drive cmd_in_ready=1 and data_in_ready=1; reset mid-burst SHALL discard all queued content.

Verification
REQ-021 STORE_FWD=1: write cmd (len=3), then beats 0-2 -> cmd_out_valid stays 0; beat 3 with last=1 -> cmd_out_valid=1 next cycle, burst_count=1.
REQ-022 STORE_FWD=0: write cmd, then one beat without last -> cmd_out_valid=1 one cycle later; data_out_valid=0 until the cmd_out handshake, then 1.
REQ-023 Fill: 32 beats with data_out_ready=0 -> data_count=32, data_in_ready=0; one read -> data_in_ready=1 next cycle, data_count=31.
REQ-024 Simultaneous: data_in last and data_out last in the same cycle with burst_count=1 -> burst_count stays 1, open_burst=0.
REQ-025 Error: 17 beats without last (MAX_BURST_LEN=16) -> err_burst_len=1 after beat 16 and stays 1 until rst.
REQ-026 Reset: assert rst with 2 commands and 5 beats queued -> all counts 0, both valids 0 immediately, no stale data after release.
